// File: rtl/weight_updater_pkg.sv
// Shared signed Q-format constants, FSM encoding and saturation helpers for
// the weight update datapath and its sibling training stages.
package weight_updater_pkg;

  localparam int unsigned Q_FIXED_BITS = 8;
  localparam int unsigned Q_FRAC_BITS  = 8;
  localparam int unsigned Q_W          = Q_FIXED_BITS + Q_FRAC_BITS;

  localparam logic signed [Q_W-1:0] Q_MAX = {1'b0, {(Q_W-1){1'b1}}};
  localparam logic signed [Q_W-1:0] Q_MIN = {1'b1, {(Q_W-1){1'b0}}};
  localparam logic signed [Q_W-1:0] Q_ONE = Q_W'(1 << Q_FRAC_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    APPLY = 2'd2,
    DONE  = 2'd3
  } wu_state_t;

  // Bounds of a w-bit signed word, expressed in a 64-bit signed carrier.
  function automatic logic signed [63:0] q_bound_hi(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] q_bound_lo(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  function automatic logic q_out_of_range(input logic signed [63:0] x,
                                          input int unsigned       w);
    return (x > q_bound_hi(w)) || (x < q_bound_lo(w));
  endfunction

  function automatic logic signed [63:0] q_clamp(input logic signed [63:0] x,
                                                 input int unsigned       w);
    if (x > q_bound_hi(w)) return q_bound_hi(w);
    if (x < q_bound_lo(w)) return q_bound_lo(w);
    return x;
  endfunction

endpackage

// File: rtl/weight_updater_if.sv
// Request/result bundle between the weight updater, its requester and the
// weight store / gradient register.
interface weight_updater_if #(
  parameter int unsigned W = 16
);
  logic         start;
  logic         ready;
  logic [W-1:0] gradient_in;
  logic [W-1:0] weight_in;
  logic [W-1:0] learning_rate;
  logic [W-1:0] weight_out;
  logic         done;
  logic         grad_clear;
  logic         saturated;

  modport master (
    output start, gradient_in, weight_in, learning_rate,
    input  ready, weight_out, done, grad_clear, saturated
  );

  modport slave (
    input  start, gradient_in, weight_in, learning_rate,
    output ready, weight_out, done, grad_clear, saturated
  );
endinterface

// File: rtl/weight_updater_seq_mult_unsigned.sv
// Iterative W-cycle shift-add unsigned multiplier; operands sampled on start
// while idle, product valid the cycle after done.
module seq_mult_unsigned #(
  parameter int unsigned W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [2*W-1:0] mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (busy_q) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      if (cnt_q == LAST) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (start) begin
      mcand_d  = {{W{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end
  end

  // done flags the final accumulate step; acc_q holds the full product after it.
  assign done    = busy_q && (cnt_q == LAST);
  assign busy    = busy_q;
  assign product = acc_q;

endmodule

// File: rtl/weight_updater.sv
// new_weight = weight - learning_rate * gradient in signed Q format with
// saturation, using a shared iterative multiplier on operand magnitudes.
module weight_updater
  import weight_updater_pkg::*;
#(
  parameter int unsigned FIXED_BITS      = Q_FIXED_BITS,
  parameter int unsigned FRACTIONAL_BITS = Q_FRAC_BITS
) (
  input  logic             clk,
  input  logic             rst,
  weight_updater_if.slave  bus
);
  localparam int unsigned W = FIXED_BITS + FRACTIONAL_BITS;

  wu_state_t        state_q, state_d;
  logic [W-1:0]     weight_q, weight_d;
  logic             sign_q, sign_d;
  logic [W-1:0]     weight_out_q, weight_out_d;
  logic             saturated_q, saturated_d;

  logic             ready;
  logic             accept;
  logic [W-1:0]     grad_mag;
  logic [W-1:0]     lr_mag;
  logic             mult_busy;
  logic             mult_done;
  logic [2*W-1:0]   mult_product;

  logic [2*W-1:0]          scaled_mag;
  logic signed [2*W+1:0]   scaled;
  logic signed [2*W+1:0]   weight_ext;
  logic signed [2*W+1:0]   diff;
  logic signed [63:0]      diff_wide;

  // Two's-complement magnitude; the most negative value maps to 2^(W-1).
  assign grad_mag = bus.gradient_in[W-1]   ? (~bus.gradient_in + W'(1))   : bus.gradient_in;
  assign lr_mag   = bus.learning_rate[W-1] ? (~bus.learning_rate + W'(1)) : bus.learning_rate;

  assign ready  = (state_q == IDLE) && !mult_busy;
  assign accept = bus.start && ready;

  seq_mult_unsigned #(.W(W)) u_mult (
    .clk     (clk),
    .rst     (rst),
    .start   (accept),
    .a       (grad_mag),
    .b       (lr_mag),
    .busy    (mult_busy),
    .done    (mult_done),
    .product (mult_product)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      weight_q     <= '0;
      sign_q       <= 1'b0;
      weight_out_q <= '0;
      saturated_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      weight_q     <= weight_d;
      sign_q       <= sign_d;
      weight_out_q <= weight_out_d;
      saturated_q  <= saturated_d;
    end
  end

  // Truncating the magnitude before applying the sign rounds toward zero.
  always_comb begin
    scaled_mag = mult_product >> FRACTIONAL_BITS;
    scaled     = sign_q ? -$signed({2'b00, scaled_mag}) : $signed({2'b00, scaled_mag});
    weight_ext = {{(W+2){weight_q[W-1]}}, weight_q};
    diff       = weight_ext - scaled;
    diff_wide  = 64'(diff);
  end

  always_comb begin
    state_d      = state_q;
    weight_d     = weight_q;
    sign_d       = sign_q;
    weight_out_d = weight_out_q;
    saturated_d  = saturated_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          weight_d = bus.weight_in;
          sign_d   = bus.gradient_in[W-1] ^ bus.learning_rate[W-1];
          state_d  = MUL;
        end
      end
      MUL: begin
        if (mult_done) state_d = APPLY;
      end
      APPLY: begin
        weight_out_d = W'(q_clamp(diff_wide, W));
        saturated_d  = q_out_of_range(diff_wide, W);
        state_d      = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ready      = ready;
  assign bus.done       = (state_q == DONE);
  assign bus.grad_clear = (state_q == DONE);
  assign bus.weight_out = weight_out_q;
  assign bus.saturated  = saturated_q;

endmodule

// File: doc/weight_updater.md
Name: weight_updater

Overview:
- Downstream consumer of the per-connection gradient register.
- Computes new_weight = weight − learning_rate × gradient in signed Q(FIXED_BITS).(FRACTIONAL_BITS), with saturation.
- Uses an iterative shift-add multiplier to save area.
- On completion, pulses a clear request back to the gradient register and presents the updated weight to the weight store.

Parameters:
- FIXED_BITS, 8, integer bits including sign.
- FRACTIONAL_BITS, 8, fractional bits.
- W (localparam), FIXED_BITS+FRACTIONAL_BITS, word width.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted when start & ready
- ready  output  1  high only in IDLE
- gradient_in  input  W  signed Q gradient, sampled on accept
- weight_in  input  W  signed Q current weight, sampled on accept
- learning_rate  input  W  signed Q learning rate, sampled on accept
- weight_out  output  W  signed Q updated weight
- done  output  1  one-cycle pulse; weight_out valid
- grad_clear  output  1  one-cycle pulse coincident with done; drives gradient clear_en
- saturated  output  1  high with done if the result was clamped

Behaviour:
- Interface: one clock, clk; reset rst, synchronous active-high.
- Reset values:
  - ready = 1
  - done = 0, grad_clear = 0, saturated = 0
  - weight_out = 0
  - state = IDLE, counter = 0
- FSM: IDLE → MUL → APPLY → DONE → IDLE.
- IDLE:
  - On start & ready, latch the operands.
  - Form unsigned magnitudes |gradient_in| and |learning_rate| in W bits (0x8000 → 32768, no overflow).
  - Form sign = sign(g) XOR sign(lr).
  - Clear the 2W-bit accumulator and go to MUL.
- MUL:
  - Exactly W cycles. Each cycle: if multiplier LSB is 1, add the shifted multiplicand; shift; counter++.
  - Leave when counter == W−1.
- APPLY (1 cycle):
  - scaled = product >> FRACTIONAL_BITS (magnitude truncation, i.e. toward zero); negate if sign.
  - diff = weight − scaled, computed in 2W+2 signed bits.
  - Clamp to [−2^(W−1), 2^(W−1)−1] and register into weight_out.
  - saturated = 1 if clamped, else 0.
- DONE (1 cycle): done = 1, grad_clear = 1. Next state IDLE.
- Latency: accept at cycle t → done at t+W+2. Throughput: one update per W+3 cycles.
- weight_out and saturated hold their values until the next APPLY.
- While ready = 0 (MUL/APPLY/DONE), start is ignored; operands are not resampled.
- Any-state rst returns all outputs to their reset values on the next edge. The in-flight result is discarded and no grad_clear is issued.
- Operand changes after accept have no effect.

Decomposition:
- Shared q_format package:
  - W, Q_MAX = 2^(W−1)−1, Q_MIN = −2^(W−1)
  - Q_ONE = 1 << FRACTIONAL_BITS
  - saturating-clamp function
  - FSM state encoding (IDLE=0, MUL=1, APPLY=2, DONE=3)
- Sub-module seq_mult_unsigned:
  - Ports: start, busy, done, a, b, product[2W−1:0].
  - W-cycle shift-add multiplier, reusable by the delta/backprop stage.

Test Plan:
- Basic update: g=0x0100 (1.0), lr=0x0080 (0.5), w=0x0200 (2.0) → done at accept+18, weight_out=0x0180, saturated=0, grad_clear=1 same cycle.
- Positive saturation: g=0xFF00 (−1.0), lr=0x0200 (2.0), w=0x7F00 (127.0) → weight_out=0x7FFF, saturated=1. Mirror case: g=0x0100, lr=0x0200, w=0x8100 → 0x8000, saturated=1.
- Most-negative operand and truncation:
  - g=0x8000, lr=0x0100, w=0 → 0x7FFF, saturated=1.
  - g=0x0001, lr=0x0080, w=0x0300 → 0x0300 (product truncates to 0).
  - g=0xFFFF, same lr and w → also 0x0300 (toward zero).
- Busy/back-to-back:
  - start held high continuously → accepts at t and t+19 only; ready low t+1..t+18.
  - Operands changed mid-MUL do not affect the result.
- Reset mid-operation: rst high 5 cycles after accept → next edge ready=1, done=0, weight_out=0; grad_clear never pulses for the aborted job; a following job completes normally.
- Zero cases: lr=0 or g=0 → weight_out=weight_in, saturated=0, done/grad_clear still pulse once.
